// File: rtl/hazard_controller_pkg.sv
// Shared encodings and FSM state type for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Stage fields in, pipeline controls out; slave side is the controller.
interface hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic [4:0]       RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemErr, StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_controller_forward_unit.sv
// Execute-stage operand bypass selection; Memory-stage producer has priority.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs1_e,
  input  logic [4:0] i_rs2_e,
  input  logic [4:0] i_rd_m,
  input  logic [4:0] i_rd_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b
);

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if ((rs != '0) && we_m && (rs == rd_m))
      return FWD_M;
    else if ((rs != '0) && we_w && (rs == rd_w))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign o_fwd_a = fwd_sel(i_rs1_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);
  assign o_fwd_b = fwd_sel(i_rs2_e, i_rd_m, i_reg_write_m, i_rd_w, i_reg_write_w);

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward control, memory-wait FSM with timeout, saturating perf counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t           r_state, w_state_nxt;
  logic [WCW-1:0]   r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_mem_stall, w_lw_stall;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_w, w_mem_err;

  forward_unit u_fwd (
    .i_rs1_e       (hz.Rs1E),
    .i_rs2_e       (hz.Rs2E),
    .i_rd_m        (hz.RdM),
    .i_rd_w        (hz.RdW),
    .i_reg_write_m (hz.RegWriteM),
    .i_reg_write_w (hz.RegWriteW),
    .o_fwd_a       (w_fwd_a),
    .o_fwd_b       (w_fwd_b)
  );

  assign w_mem_stall = hz.MemReqM & ~hz.MemReadyM;
  assign w_lw_stall  = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != '0) &&
                       ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE)) && !hz.PCSrcE;

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_wait_nxt  = WCW'(1);
          w_state_nxt = (MEM_TIMEOUT <= 1) ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (!w_mem_stall) begin
          w_wait_nxt  = '0;
          w_state_nxt = RUN;
        end else begin
          w_wait_nxt = r_wait_cnt + WCW'(1);
          if (w_wait_nxt == WCW'(MEM_TIMEOUT))
            w_state_nxt = ERR;
        end
      end
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = RUN;
    endcase
  end

  // Memory freeze outranks load-use and redirect so those re-evaluate on release.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    w_mem_err = 1'b0;
    if (rst) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      w_flush_w = 1'b1;
    end else if (r_state == ERR) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
      w_mem_err = 1'b1;
    end else if (w_mem_stall) begin
      w_stall_f = 1'b1;
      w_stall_d = 1'b1;
      w_stall_e = 1'b1;
      w_stall_m = 1'b1;
      w_flush_w = 1'b1;
    end else begin
      w_stall_f = w_lw_stall;
      w_stall_d = w_lw_stall;
      w_flush_d = hz.PCSrcE;
      w_flush_e = w_lw_stall | hz.PCSrcE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall_f && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_e && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.StallF     = w_stall_f;
  assign hz.StallD     = w_stall_d;
  assign hz.StallE     = w_stall_e;
  assign hz.StallM     = w_stall_m;
  assign hz.FlushD     = w_flush_d;
  assign hz.FlushE     = w_flush_e;
  assign hz.FlushW     = w_flush_w;
  assign hz.MemErr     = w_mem_err;
  assign hz.ForwardAE  = rst ? FWD_RF : w_fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : w_fwd_b;
  assign hz.StallCount = r_stall_cnt;
  assign hz.FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_hazard_controller;

  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CW)) hz ();

  hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    logic       sf, sd, se, sm, fd, fe, fw, me;
    logic [1:0] fa, fb;
    int         sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // stimulus staging
  logic       s_rst;
  logic [4:0] s_rs1d, s_rs2d, s_rs1e, s_rs2e, s_rde, s_rdm, s_rdw;
  logic       s_rwm, s_rww, s_pc, s_req, s_rdy;
  logic [1:0] s_rsrc;

  // reference model state
  bit m_err;
  int m_waits, m_sc, m_fc;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && s_rwm && rs == s_rdm) return 2'b10;
    if (rs != 0 && s_rww && rs == s_rdw) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear();
    s_rst = 0; s_rs1d = 0; s_rs2d = 0; s_rs1e = 0; s_rs2e = 0; s_rde = 0;
    s_rdm = 0; s_rdw = 0; s_rwm = 0; s_rww = 0; s_pc = 0; s_req = 0; s_rdy = 0;
    s_rsrc = 0;
  endtask

  task automatic drive();
    rst = s_rst;
    hz.Rs1D = s_rs1d; hz.Rs2D = s_rs2d; hz.Rs1E = s_rs1e; hz.Rs2E = s_rs2e;
    hz.RdE = s_rde; hz.RdM = s_rdm; hz.RdW = s_rdw;
    hz.RegWriteM = s_rwm; hz.RegWriteW = s_rww; hz.ResultSrcE = s_rsrc;
    hz.PCSrcE = s_pc; hz.MemReqM = s_req; hz.MemReadyM = s_rdy;
  endtask

  task automatic step();
    exp_t e;
    bit   mem, lu;
    @(posedge clk);
    #1;
    drive();
    mem = s_req && !s_rdy;
    lu  = (s_rsrc == 2'b01) && (s_rde != 0) && (s_rs1d == s_rde || s_rs2d == s_rde) && !s_pc;
    e = '{default: 0};
    e.fa = ref_fwd(s_rs1e);
    e.fb = ref_fwd(s_rs2e);
    if (s_rst) begin
      e.fd = 1; e.fe = 1; e.fw = 1; e.fa = 0; e.fb = 0;
    end else if (m_err || mem) begin
      e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1; e.me = m_err;
    end else begin
      e.sf = lu; e.sd = lu; e.fe = lu || s_pc; e.fd = s_pc;
    end
    e.sc = m_sc;
    e.fc = m_fc;
    q.push_back(e);
    if (s_rst) begin
      m_err = 0; m_waits = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e.sf) m_sc = (m_sc + 1 > SAT) ? SAT : m_sc + 1;
      if (e.fe) m_fc = (m_fc + 1 > SAT) ? SAT : m_fc + 1;
      if (!m_err) begin
        if (mem) begin
          m_waits++;
          if (m_waits >= MT) m_err = 1;
        end else begin
          m_waits = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("StallF", 32'(hz.StallF), 32'(e.sf));
      chk("StallD", 32'(hz.StallD), 32'(e.sd));
      chk("StallE", 32'(hz.StallE), 32'(e.se));
      chk("StallM", 32'(hz.StallM), 32'(e.sm));
      chk("FlushD", 32'(hz.FlushD), 32'(e.fd));
      chk("FlushE", 32'(hz.FlushE), 32'(e.fe));
      chk("FlushW", 32'(hz.FlushW), 32'(e.fw));
      chk("ForwardAE", 32'(hz.ForwardAE), 32'(e.fa));
      chk("ForwardBE", 32'(hz.ForwardBE), 32'(e.fb));
      chk("MemErr", 32'(hz.MemErr), 32'(e.me));
      chk("StallCount", 32'(hz.StallCount), 32'(e.sc));
      chk("FlushCount", 32'(hz.FlushCount), 32'(e.fc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear();
    s_rst = 1;
    drive();
    m_err = 0; m_waits = 0; m_sc = 0; m_fc = 0;
    // counters become defined after the first reset edge; checking starts after it
    @(posedge clk);
    step();
    step();

    // forwarding
    clear(); s_rdm = 5; s_rwm = 1; s_rdw = 5; s_rww = 1; s_rs1e = 5; step();
    clear(); s_rdm = 0; s_rwm = 1; s_rs1e = 0; step();
    clear(); s_rs2e = 7; s_rdw = 7; s_rww = 1; step();

    // load-use, then redirect in the same cycle as load-use
    clear(); s_rsrc = 2'b01; s_rde = 3; s_rs2d = 3; step();
    clear(); step();
    clear(); s_rsrc = 2'b01; s_rde = 3; s_rs2d = 3; s_pc = 1; step();
    clear(); step();

    // three-cycle memory wait
    clear(); s_req = 1;
    repeat (3) step();
    s_rdy = 1; step();
    clear(); step();

    // load-use masked by a memory wait
    clear(); s_rsrc = 2'b01; s_rde = 4; s_rs1d = 4; s_req = 1; step();
    s_rdy = 1; step();
    clear(); step();

    // timeout into ERR, then reset out
    clear(); s_req = 1;
    repeat (MT + 4) step();
    clear(); s_rst = 1; step();
    clear(); step(); step();

    // ready arriving on the MEM_TIMEOUT-th wait cycle completes the access
    clear(); s_req = 1;
    repeat (MT - 1) step();
    s_rdy = 1; step();
    clear(); step();

    // counter saturation
    clear(); s_rsrc = 2'b01; s_rde = 9; s_rs1d = 9;
    repeat (SAT + 4) step();
    clear(); s_rst = 1; step();
    clear(); step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      s_rst  = ($urandom_range(0, 39) == 0);
      s_rs1d = 5'($urandom_range(0, 7));
      s_rs2d = 5'($urandom_range(0, 7));
      s_rs1e = 5'($urandom_range(0, 7));
      s_rs2e = 5'($urandom_range(0, 7));
      s_rde  = 5'($urandom_range(0, 7));
      s_rdm  = 5'($urandom_range(0, 7));
      s_rdw  = 5'($urandom_range(0, 7));
      s_rwm  = 1'($urandom_range(0, 1));
      s_rww  = 1'($urandom_range(0, 1));
      s_rsrc = 2'($urandom_range(0, 3));
      s_pc   = ($urandom_range(0, 4) == 0);
      s_req  = ($urandom_range(0, 2) == 0);
      s_rdy  = 1'($urandom_range(0, 1));
      step();
    end
    clear(); step();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
